// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//   Writeback stage plus the 32 x 32-bit register file of a 5-stage MIPS-style
//   pipeline. It selects the writeback value from the MEM/WB register, commits
//   it to the array, and serves two combinational decode-stage read ports.
//   Register 0 is hard-wired to zero. A free-running counter tracks committed
//   writes.
//
// Configuration
//   WB_REGFILE_BYPASS_EN : when defined, a read port whose index matches the
//                          register being written this cycle returns the
//                          writeback value straight away (write-through).
//                          Undefined (default): reads return the stored value
//                          until the cycle after the commit.
//
// Parameters
//   JAL_OFFSET    : added to PC_i to form the link address (MemtoReg_i = 2'b10)
//
// Ports
//   clk           : clock, all state updates on its rising edge
//   reset         : synchronous, active-high; clears registers and counter
//   RegWr_i       : write enable from MEM/WB
//   MemtoReg_i    : writeback source (00 ALU, 01 load data, 10 PC+offset, 11 ALU)
//   ALUOut_i      : ALU result
//   MemReadData_i : load data
//   RegDstAddr_i  : destination register index
//   PC_i          : instruction PC, used for the jal link value
//   RsAddr_i      : read port A index
//   RtAddr_i      : read port B index
//   RsData_o      : read port A data (combinational)
//   RtData_o      : read port B data (combinational)
//   WbData_o      : selected writeback value (forwarding source)
//   WbCount_o     : registered count of committed writes, wraps at 2^32
// -----------------------------------------------------------------------------
module wb_regfile #(
    parameter logic [31:0] JAL_OFFSET = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWr_i,
    input  logic [1:0]  MemtoReg_i,
    input  logic [31:0] ALUOut_i,
    input  logic [31:0] MemReadData_i,
    input  logic [4:0]  RegDstAddr_i,
    input  logic [31:0] PC_i,
    input  logic [4:0]  RsAddr_i,
    input  logic [4:0]  RtAddr_i,
    output logic [31:0] RsData_o,
    output logic [31:0] RtData_o,
    output logic [31:0] WbData_o,
    output logic [31:0] WbCount_o
);

    logic [31:0] r_regs [32];
    logic [31:0] r_wb_count;

    logic [31:0] w_wb_data;
    logic        w_commit;
    logic [31:0] w_rs_stored;
    logic [31:0] w_rt_stored;

    // Writeback source select.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first, so
        // no path through the block leaves it unassigned and infers a latch.
        w_wb_data = ALUOut_i;
        case (MemtoReg_i)
            2'b01:   w_wb_data = MemReadData_i;
            2'b10:   w_wb_data = PC_i + JAL_OFFSET;
            default: w_wb_data = ALUOut_i;
        endcase
    end

    // A write commits only outside reset and never to register 0; the same
    // qualifier gates both the array update and the bypass.
    assign w_commit = RegWr_i && !reset && (RegDstAddr_i != 5'd0);

    // Index 0 is muxed to zero on read, so its storage contents never matter.
    assign w_rs_stored = (RsAddr_i == 5'd0) ? 32'h0 : r_regs[RsAddr_i];
    assign w_rt_stored = (RtAddr_i == 5'd0) ? 32'h0 : r_regs[RtAddr_i];

`ifdef WB_REGFILE_BYPASS_EN
    // Write-through: a matching index implies a non-zero index, because
    // w_commit already excludes register 0 and reset.
    assign RsData_o = (w_commit && (RsAddr_i == RegDstAddr_i)) ? w_wb_data : w_rs_stored;
    assign RtData_o = (w_commit && (RtAddr_i == RegDstAddr_i)) ? w_wb_data : w_rt_stored;
`else
    assign RsData_o = w_rs_stored;
    assign RtData_o = w_rt_stored;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: the array is cleared on reset because the architecture
            // requires all registers to read zero afterwards; this keeps it in
            // flops rather than a RAM macro, which is fine at 32 entries.
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'h0;
            end
            r_wb_count <= 32'h0;
        end else if (w_commit) begin
            r_regs[RegDstAddr_i] <= w_wb_data;
            r_wb_count           <= r_wb_count + 32'd1;
        end
    end

    assign WbData_o  = w_wb_data;
    assign WbCount_o = r_wb_count;

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
//   Directed, self-checking bench for wb_regfile. Each task drives one scenario
//   and compares outputs against hand-computed values. Inputs change 1 ns after
//   the rising edge and outputs are sampled there too, away from the edge.
//   Expectations for same-cycle reads follow WB_REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic        RegWr_i;
    logic [1:0]  MemtoReg_i;
    logic [31:0] ALUOut_i;
    logic [31:0] MemReadData_i;
    logic [4:0]  RegDstAddr_i;
    logic [31:0] PC_i;
    logic [4:0]  RsAddr_i;
    logic [4:0]  RtAddr_i;
    logic [31:0] RsData_o;
    logic [31:0] RtData_o;
    logic [31:0] WbData_o;
    logic [31:0] WbCount_o;

    int vectors;
    int miscompares;

    wb_regfile dut (
        .clk           (clk),
        .reset         (reset),
        .RegWr_i       (RegWr_i),
        .MemtoReg_i    (MemtoReg_i),
        .ALUOut_i      (ALUOut_i),
        .MemReadData_i (MemReadData_i),
        .RegDstAddr_i  (RegDstAddr_i),
        .PC_i          (PC_i),
        .RsAddr_i      (RsAddr_i),
        .RtAddr_i      (RtAddr_i),
        .RsData_o      (RsData_o),
        .RtData_o      (RtData_o),
        .WbData_o      (WbData_o),
        .WbCount_o     (WbCount_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge, leaving time for outputs to settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        RegWr_i       = 1'b0;
        MemtoReg_i    = 2'b00;
        ALUOut_i      = 32'h0;
        MemReadData_i = 32'h0;
        RegDstAddr_i  = 5'd0;
        PC_i          = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RsAddr_i = 5'd5;
        RtAddr_i = 5'd0;
        reset    = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        vectors++;
        if (WbCount_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_count: got %h expected %h", WbCount_o, 32'h0);
        end
        vectors++;
        if (RsData_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rs5: got %h expected %h", RsData_o, 32'h0);
        end
        vectors++;
        if (RtData_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rt0: got %h expected %h", RtData_o, 32'h0);
        end
    endtask

    task automatic test_basic_write();
        RegWr_i      = 1'b1;
        MemtoReg_i   = 2'b00;
        ALUOut_i     = 32'h1234_5678;
        RegDstAddr_i = 5'd5;
        #1;
        vectors++;
        if (WbData_o !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL wbdata_alu: got %h expected %h", WbData_o, 32'h1234_5678);
        end
        step();
        idle_inputs();
        RsAddr_i = 5'd5;
        #1;
        vectors++;
        if (RsData_o !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL basic_rs5: got %h expected %h", RsData_o, 32'h1234_5678);
        end
        vectors++;
        if (WbCount_o !== 32'd1) begin
            miscompares++;
            $display("FAIL basic_count: got %h expected %h", WbCount_o, 32'd1);
        end
    endtask

    task automatic test_reg0();
        RegWr_i      = 1'b1;
        MemtoReg_i   = 2'b00;
        ALUOut_i     = 32'hFFFF_FFFF;
        RegDstAddr_i = 5'd0;
        RsAddr_i     = 5'd0;
        RtAddr_i     = 5'd0;
        #1;
        vectors++;
        if (RsData_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reg0_same_cycle: got %h expected %h", RsData_o, 32'h0);
        end
        step();
        idle_inputs();
        #1;
        vectors++;
        if (RsData_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reg0_rs: got %h expected %h", RsData_o, 32'h0);
        end
        vectors++;
        if (RtData_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reg0_rt: got %h expected %h", RtData_o, 32'h0);
        end
        vectors++;
        if (WbCount_o !== 32'd1) begin
            miscompares++;
            $display("FAIL reg0_count: got %h expected %h", WbCount_o, 32'd1);
        end
    endtask

    task automatic test_wb_mux();
        // Link write: PC + 4.
        RegWr_i      = 1'b1;
        MemtoReg_i   = 2'b10;
        ALUOut_i     = 32'h1111_1111;
        PC_i         = 32'h0040_0010;
        RegDstAddr_i = 5'd31;
        #1;
        vectors++;
        if (WbData_o !== 32'h0040_0014) begin
            miscompares++;
            $display("FAIL wbdata_link: got %h expected %h", WbData_o, 32'h0040_0014);
        end
        step();
        // Load write.
        MemtoReg_i    = 2'b01;
        MemReadData_i = 32'hDEAD_BEEF;
        ALUOut_i      = 32'h2222_2222;
        RegDstAddr_i  = 5'd8;
        #1;
        vectors++;
        if (WbData_o !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL wbdata_load: got %h expected %h", WbData_o, 32'hDEAD_BEEF);
        end
        step();
        // Select 11 falls back to the ALU result.
        MemtoReg_i    = 2'b11;
        ALUOut_i      = 32'h0BAD_F00D;
        MemReadData_i = 32'h3333_3333;
        PC_i          = 32'h4444_4444;
        RegDstAddr_i  = 5'd10;
        #1;
        vectors++;
        if (WbData_o !== 32'h0BAD_F00D) begin
            miscompares++;
            $display("FAIL wbdata_sel11: got %h expected %h", WbData_o, 32'h0BAD_F00D);
        end
        step();
        idle_inputs();
        RsAddr_i = 5'd31;
        RtAddr_i = 5'd8;
        #1;
        vectors++;
        if (RsData_o !== 32'h0040_0014) begin
            miscompares++;
            $display("FAIL mux_r31: got %h expected %h", RsData_o, 32'h0040_0014);
        end
        vectors++;
        if (RtData_o !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL mux_r8: got %h expected %h", RtData_o, 32'hDEAD_BEEF);
        end
        RsAddr_i = 5'd10;
        #1;
        vectors++;
        if (RsData_o !== 32'h0BAD_F00D) begin
            miscompares++;
            $display("FAIL mux_r10: got %h expected %h", RsData_o, 32'h0BAD_F00D);
        end
        vectors++;
        if (WbCount_o !== 32'd4) begin
            miscompares++;
            $display("FAIL mux_count: got %h expected %h", WbCount_o, 32'd4);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same;
`ifdef WB_REGFILE_BYPASS_EN
        exp_same = 32'hA5A5_A5A5;
`else
        exp_same = 32'h0;
`endif
        RegWr_i      = 1'b1;
        MemtoReg_i   = 2'b00;
        ALUOut_i     = 32'hA5A5_A5A5;
        RegDstAddr_i = 5'd9;
        RtAddr_i     = 5'd9;
        RsAddr_i     = 5'd8;
        #1;
        vectors++;
        if (RtData_o !== exp_same) begin
            miscompares++;
            $display("FAIL bypass_same_cycle_rt: got %h expected %h", RtData_o, exp_same);
        end
        // The other port, on an unrelated index, keeps its stored value.
        vectors++;
        if (RsData_o !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL bypass_other_port: got %h expected %h", RsData_o, 32'hDEAD_BEEF);
        end
        step();
        idle_inputs();
        RsAddr_i = 5'd9;
        #1;
        vectors++;
        if (RsData_o !== 32'hA5A5_A5A5) begin
            miscompares++;
            $display("FAIL bypass_next_rs: got %h expected %h", RsData_o, 32'hA5A5_A5A5);
        end
        vectors++;
        if (RtData_o !== 32'hA5A5_A5A5) begin
            miscompares++;
            $display("FAIL bypass_next_rt: got %h expected %h", RtData_o, 32'hA5A5_A5A5);
        end
    endtask

    task automatic test_back_to_back();
        // Writes on consecutive edges, including an overwrite of reg 12.
        RegWr_i      = 1'b1;
        MemtoReg_i   = 2'b00;
        ALUOut_i     = 32'h0000_0C0C;
        RegDstAddr_i = 5'd12;
        step();
        ALUOut_i     = 32'h0000_0D0D;
        RegDstAddr_i = 5'd13;
        step();
        ALUOut_i     = 32'hC0DE_0012;
        RegDstAddr_i = 5'd12;
        step();
        idle_inputs();
        RsAddr_i = 5'd12;
        RtAddr_i = 5'd13;
        #1;
        vectors++;
        if (RsData_o !== 32'hC0DE_0012) begin
            miscompares++;
            $display("FAIL b2b_r12: got %h expected %h", RsData_o, 32'hC0DE_0012);
        end
        vectors++;
        if (RtData_o !== 32'h0000_0D0D) begin
            miscompares++;
            $display("FAIL b2b_r13: got %h expected %h", RtData_o, 32'h0000_0D0D);
        end
        vectors++;
        if (WbCount_o !== 32'd8) begin
            miscompares++;
            $display("FAIL b2b_count: got %h expected %h", WbCount_o, 32'd8);
        end
    endtask

    task automatic test_reset_priority();
        int          bad;
        logic [31:0] exp;
        // Fill registers 1..31 with a per-index pattern.
        RegWr_i    = 1'b1;
        MemtoReg_i = 2'b00;
        for (int i = 1; i < 32; i++) begin
            RegDstAddr_i = 5'(i);
            ALUOut_i     = 32'h0101_0101 * 32'(i);
            step();
        end
        idle_inputs();
        bad = 0;
        for (int i = 1; i < 32; i++) begin
            RsAddr_i = 5'(i);
            RtAddr_i = 5'(i);
            exp      = 32'h0101_0101 * 32'(i);
            #1;
            if (RsData_o !== exp || RtData_o !== exp) begin
                bad++;
                $display("FAIL fill_r%0d: got rs %h rt %h expected %h", i, RsData_o, RtData_o, exp);
            end
        end
        vectors++;
        if (bad != 0) miscompares++;
        vectors++;
        if (WbCount_o !== 32'd39) begin
            miscompares++;
            $display("FAIL fill_count: got %h expected %h", WbCount_o, 32'd39);
        end
        // Reset with a concurrent write to reg 3; the read sees the stored value.
        reset        = 1'b1;
        RegWr_i      = 1'b1;
        ALUOut_i     = 32'h3333_3333;
        RegDstAddr_i = 5'd3;
        RsAddr_i     = 5'd3;
        RtAddr_i     = 5'd3;
        #1;
        vectors++;
        if (RsData_o !== 32'h0303_0303) begin
            miscompares++;
            $display("FAIL no_bypass_in_reset: got %h expected %h", RsData_o, 32'h0303_0303);
        end
        step();
        reset = 1'b0;
        idle_inputs();
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            RsAddr_i = 5'(i);
            RtAddr_i = 5'(31 - i);
            #1;
            if (RsData_o !== 32'h0 || RtData_o !== 32'h0) begin
                bad++;
                $display("FAIL cleared_r%0d: got rs %h rt %h expected 0", i, RsData_o, RtData_o);
            end
        end
        vectors++;
        if (bad != 0) miscompares++;
        vectors++;
        if (WbCount_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_count: got %h expected %h", WbCount_o, 32'h0);
        end
        // Writes resume on the first edge with reset low.
        RegWr_i      = 1'b1;
        ALUOut_i     = 32'h0000_0333;
        RegDstAddr_i = 5'd3;
        step();
        idle_inputs();
        RsAddr_i = 5'd3;
        #1;
        vectors++;
        if (RsData_o !== 32'h0000_0333) begin
            miscompares++;
            $display("FAIL resume_r3: got %h expected %h", RsData_o, 32'h0000_0333);
        end
        vectors++;
        if (WbCount_o !== 32'd1) begin
            miscompares++;
            $display("FAIL resume_count: got %h expected %h", WbCount_o, 32'd1);
        end
    endtask

    task automatic test_count_wrap();
        // Preload the counter near its limit instead of issuing 2^32 writes.
        force dut.r_wb_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_wb_count;
        #1;
        vectors++;
        if (WbCount_o !== 32'hFFFF_FFFE) begin
            miscompares++;
            $display("FAIL wrap_preload: got %h expected %h", WbCount_o, 32'hFFFF_FFFE);
        end
        RegWr_i      = 1'b1;
        MemtoReg_i   = 2'b00;
        ALUOut_i     = 32'h0000_0014;
        RegDstAddr_i = 5'd20;
        step();
        vectors++;
        if (WbCount_o !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL wrap_max: got %h expected %h", WbCount_o, 32'hFFFF_FFFF);
        end
        ALUOut_i     = 32'h0000_0015;
        RegDstAddr_i = 5'd21;
        step();
        idle_inputs();
        RsAddr_i = 5'd21;
        #1;
        vectors++;
        if (WbCount_o !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_zero: got %h expected %h", WbCount_o, 32'h0);
        end
        vectors++;
        if (RsData_o !== 32'h0000_0015) begin
            miscompares++;
            $display("FAIL wrap_r21: got %h expected %h", RsData_o, 32'h0000_0015);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        RsAddr_i    = 5'd0;
        RtAddr_i    = 5'd0;
        idle_inputs();
        #2;
        test_reset();
        test_basic_write();
        test_reg0();
        test_wb_mux();
        test_bypass();
        test_back_to_back();
        test_reset_priority();
        test_count_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have parameter JAL_OFFSET, default 32'd4, the offset added to PC_i for link writes (MemtoReg_i = 2'b10).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous and active-high.
REQ-004 The block SHALL have port RegWr_i, input, 1, write enable from the MEM/WB stage register.
REQ-005 The block SHALL have port MemtoReg_i, input, 2, writeback source select.
REQ-006 The block SHALL have port ALUOut_i, input, 32, ALU result from MEM/WB.
REQ-007 The block SHALL have port MemReadData_i, input, 32, load data from MEM/WB.
REQ-008 The block SHALL have port RegDstAddr_i, input, 5, destination register index.
REQ-009 The block SHALL have port PC_i, input, 32, instruction PC, used for jal link.
REQ-010 The block SHALL have ports RsAddr_i and RtAddr_i, input, 5 each, decode-stage read indices.
REQ-011 The block SHALL have ports RsData_o and RtData_o, output, 32 each, combinational read data.
REQ-012 The block SHALL have port WbData_o, output, 32, combinational selected writeback value (forwarding source).
REQ-013 The block SHALL have port WbCount_o, output, 32, registered count of committed writes.

Function
REQ-014 WbData_o SHALL be ALUOut_i for MemtoReg_i=2'b00, MemReadData_i for 2'b01, PC_i+JAL_OFFSET (mod 2^32) for 2'b10, ALUOut_i for 2'b11.
REQ-015 A write SHALL commit on the rising clk edge when RegWr_i=1, reset=0 and RegDstAddr_i!=0: regs[RegDstAddr_i] <= WbData_o.
REQ-016 Register 0 SHALL read 32'h0 always; writes to index 0 SHALL be discarded and SHALL NOT count.
REQ-017 Reads SHALL be combinational: RsData_o = regs[RsAddr_i], RtData_o = regs[RtAddr_i] (subject to REQ-023).
REQ-018 WbCount_o SHALL increment by 1 on every committed write (REQ-015), wrapping 32'hFFFFFFFF -> 0.
REQ-019 Write latency SHALL be one cycle: value is readable from the register array in the cycle after the commit edge.
REQ-020 Both read ports SHALL be independent; Rs and Rt addressing the same index SHALL return identical data.

Reset
REQ-021 While reset=1 at a clk edge, all 31 writable registers SHALL clear to 32'h0 and WbCount_o SHALL clear to 0; any concurrent write SHALL be dropped.
REQ-022 Reset asserted mid-sequence SHALL take priority over RegWr_i; writes resume on the first edge with reset=0.

Configuration
REQ-023 With macro WB_REGFILE_BYPASS_EN defined, a read port whose index equals RegDstAddr_i while RegWr_i=1 and index!=0 SHALL return WbData_o in the same cycle (write-through); without it, the port SHALL return the stored (old) value until the next cycle.
REQ-024 The bypass SHALL NOT apply during reset=1 in either configuration (read returns stored value).

Verification
REQ-025 Reset, then RegWr_i=1, MemtoReg_i=00, ALUOut_i=32'h1234_5678, RegDstAddr_i=5 -> next cycle RsAddr_i=5 reads 32'h1234_5678, WbCount_o=1.
REQ-026 RegWr_i=1, RegDstAddr_i=0, ALUOut_i=32'hFFFF_FFFF -> RsAddr_i=0 reads 0, WbCount_o unchanged.
REQ-027 MemtoReg_i=10, PC_i=32'h0040_0010, RegDstAddr_i=31 -> reg 31 = 32'h0040_0014; MemtoReg_i=01, MemReadData_i=32'hDEAD_BEEF, RegDstAddr_i=8 -> reg 8 = 32'hDEAD_BEEF.
REQ-028 Same-cycle write reg 9 = 32'hA5A5_A5A5 with RtAddr_i=9 (old 0) -> RtData_o=32'hA5A5_A5A5 with WB_REGFILE_BYPASS_EN, 0 without; both read A5A5_A5A5 next cycle.
REQ-029 Write regs 1..31, assert reset one cycle with RegWr_i=1 to reg 3 -> all regs read 0, WbCount_o=0.
REQ-030 Preload WbCount_o to 32'hFFFF_FFFF via repeated writes (or force) then one write -> WbCount_o=0.
